mult_div_unit: RTL and testbench

Iterative 32-bit multiply/divide unit sitting beside the ALU in the execute stage. It consumes the same A/B operand buses the ALU receives and produces the 64-bit HI/LO result pair used by mult/multu/div/divu and read back by mfhi/mflo. It is multicycle, with a Start/Busy/Done handshake that the control unit uses to stall the datapath. It also services mthi/mtlo writes.

---
 rtl/mult_div_unit.sv | 152 +++++++++++++++
 tb/tb_mult_div_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Handshake: Start accepted in IDLE, Busy for 34 cycles, one-cycle Done pulse.
// Multiply is radix-2 shift-add; divide is radix-2 restoring. Both run 32 steps.
module mult_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [1:0]  Operation,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        WriteHI,
   input  logic        WriteLO,
   output logic        Busy,
   output logic        Done,
   output logic        DivByZero,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

   state_t      state, state_nxt;
   logic [4:0]  count;
   logic [1:0]  op_q;       // [1]=divide, [0]=signed
   logic [31:0] a_q, b_q;   // raw operands as latched at Start
   logic [31:0] opnd_q;     // multiplicand or divisor magnitude
   logic [63:0] acc_q;      // {hi,lo} accumulator / {remainder,quotient}
   logic        sign_a_q, sign_b_q;

   logic        is_div, is_signed;
   logic [31:0] mag_a, mag_b;
   logic [32:0] mul_sum;
   logic [64:0] div_shift;
   logic [32:0] div_diff;
   logic [63:0] acc_step;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix, rem_fix;

   assign is_div    = op_q[1];
   assign is_signed = op_q[0];

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: IDLE -> PREP -> RUN (32 steps) -> FIX -> IDLE.
   always_comb begin
      // NOTE: default assigned first so no path leaves state_nxt unassigned,
      // which would otherwise infer a latch.
      state_nxt = state;
      case (state)
         S_IDLE: if (Start) state_nxt = S_PREP;
         S_PREP: state_nxt = S_RUN;
         S_RUN:  if (count == 5'd31) state_nxt = S_FIX;
         S_FIX:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand magnitudes, one iteration step, and sign-corrected final results.
   always_comb begin
      mag_a = (is_signed && a_q[31]) ? -a_q : a_q;
      mag_b = (is_signed && b_q[31]) ? -b_q : b_q;

      // Shift-add: conditionally add multiplicand to the upper half, shift right.
      mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);

      // Restoring division: shift left, trial-subtract divisor from the upper part.
      div_shift = {acc_q, 1'b0};
      div_diff  = div_shift[64:32] - {1'b0, opnd_q};

      if (is_div) begin
         if (!div_diff[32]) acc_step = {div_diff[31:0], div_shift[31:1], 1'b1};
         else               acc_step = div_shift[63:0];
      end else begin
         acc_step = {mul_sum, acc_q[31:1]};
      end

      prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
      quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[31:0] : acc_q[31:0];
      rem_fix  = sign_a_q ? -acc_q[63:32] : acc_q[63:32];
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         // NOTE: the working registers are reset too; an aborted operation then
         // leaves nothing behind that could later leak into HI/LO.
         Busy      <= 1'b0;
         Done      <= 1'b0;
         DivByZero <= 1'b0;
         HI        <= '0;
         LO        <= '0;
         count     <= '0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         opnd_q    <= '0;
         acc_q     <= '0;
         sign_a_q  <= 1'b0;
         sign_b_q  <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (Start) begin
                  a_q       <= A;
                  b_q       <= B;
                  op_q      <= Operation;
                  DivByZero <= 1'b0;
                  Busy      <= 1'b1;
               end else begin
                  if (WriteHI) HI <= A;
                  if (WriteLO) LO <= A;
               end
            end
            S_PREP: begin
               acc_q    <= {32'd0, is_div ? mag_a : mag_b};
               opnd_q   <= is_div ? mag_b : mag_a;
               sign_a_q <= is_signed & a_q[31];
               sign_b_q <= is_signed & b_q[31];
               count    <= '0;
            end
            S_RUN: begin
               acc_q <= acc_step;
               count <= count + 5'd1;
            end
            S_FIX: begin
               Busy <= 1'b0;
               Done <= 1'b1;
               if (is_div && b_q == 32'd0) begin
                  HI        <= a_q;
                  LO        <= '1;
                  DivByZero <= 1'b1;
               end else if (is_div) begin
                  HI <= rem_fix;
                  LO <= quo_fix;
               end else begin
                  HI <= prod_fix[63:32];
                  LO <= prod_fix[31:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a scoreboard queue holds expected
// HI/LO/DivByZero and start cycle; a monitor pops and compares on each Done.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start;
   logic [1:0]  Operation;
   logic [31:0] A, B;
   logic        WriteHI, WriteLO;
   logic        Busy, Done, DivByZero;
   logic [31:0] HI, LO;

   localparam logic [1:0] OP_MULTU = 2'b00, OP_MULT = 2'b01, OP_DIVU = 2'b10, OP_DIV = 2'b11;
   localparam int LATENCY = 34;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          start_cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   mult_div_unit dut (
      .clk(clk), .reset(reset), .Start(Start), .Operation(Operation),
      .A(A), .B(B), .WriteHI(WriteHI), .WriteLO(WriteLO),
      .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model built from the language's own arithmetic operators.
   function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input int sc);
      exp_t e;
      logic [63:0]        p;
      logic signed [63:0] sa64, sb64;
      logic signed [31:0] sa32, sb32;
      e.dbz = 1'b0;
      e.start_cyc = sc;
      case (op)
         OP_MULTU: begin
            p = {32'd0, a} * {32'd0, b};
            e.hi = p[63:32]; e.lo = p[31:0];
         end
         OP_MULT: begin
            sa64 = {{32{a[31]}}, a};
            sb64 = {{32{b[31]}}, b};
            p = sa64 * sb64;
            e.hi = p[63:32]; e.lo = p[31:0];
         end
         default: begin
            if (b == 32'd0) begin
               e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
            end else if (op == OP_DIVU) begin
               e.lo = a / b; e.hi = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               e.lo = 32'h8000_0000; e.hi = 32'd0;
            end else begin
               sa32 = a; sb32 = b;
               e.lo = sa32 / sb32; e.hi = sa32 % sb32;
            end
         end
      endcase
      return e;
   endfunction

   // Monitor: every Done pops one expectation and checks latency and results.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (Done) begin
         if (sb.size() == 0) begin
            check("spurious_done", 1'b1, 1'b0);
         end else begin
            e = sb.pop_front();
            check("latency", 64'(cyc - e.start_cyc), 64'(LATENCY));
            check("hi", HI, e.hi);
            check("lo", LO, e.lo);
            check("dbz", DivByZero, e.dbz);
         end
      end
   end

   // Called at a negedge in IDLE: drive Start for one edge and queue the expectation.
   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      Start = 1'b1; Operation = op; A = a; B = b;
      sb.push_back(model(op, a, b, cyc + 1));
      @(negedge clk);
      Start = 1'b0;
      check("busy_after_start", Busy, 1'b1);
   endtask

   // Returns at the negedge of the Done cycle, bounded by a cycle budget.
   task automatic wait_idle();
      int n = 0;
      while (Busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (Busy) check("busy_timeout", Busy, 1'b0);
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      start_op(op, a, b);
      wait_idle();
   endtask

   initial begin
      logic [31:0] hi_keep;
      reset = 1'b0; Start = 1'b0; Operation = '0; A = '0; B = '0;
      WriteHI = 1'b0; WriteLO = 1'b0;

      // Reset held two cycles, then idle with no Start.
      repeat (2) @(negedge clk);
      check("rst_hi", HI, 32'd0);
      check("rst_lo", LO, 32'd0);
      check("rst_flags", {Busy, Done, DivByZero}, 3'b000);
      reset = 1'b1;
      A = 32'h5555_AAAA; B = 32'h1234_5678;
      repeat (3) @(negedge clk);
      check("idle_hilo", {HI, LO}, 64'd0);
      check("idle_flags", {Busy, Done, DivByZero}, 3'b000);

      // Directed arithmetic cases, including signed overflow divide.
      run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7);
      run_op(OP_MULTU, 32'hFFFF_FFFD, 32'd7);
      run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2);
      run_op(OP_DIVU,  32'd100,       32'd7);
      run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
      run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000);
      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE);

      // Divide by zero; flag persists in IDLE and clears at the next Start.
      run_op(OP_DIVU, 32'h0000_1234, 32'd0);
      repeat (2) @(negedge clk);
      check("dbz_hold", DivByZero, 1'b1);
      start_op(OP_DIV, 32'hFFFF_FF00, 32'd0);
      check("dbz_cleared", DivByZero, 1'b0);
      wait_idle();
      start_op(OP_MULTU, 32'd3, 32'd5);
      check("dbz_cleared2", DivByZero, 1'b0);
      wait_idle();

      // Activity while Busy is ignored; Start and operand changes have no effect.
      hi_keep = HI;
      start_op(OP_MULT, 32'h0001_2345, 32'hFFFF_0003);
      repeat (4) @(negedge clk);
      Start = 1'b1; WriteHI = 1'b1; WriteLO = 1'b1; Operation = OP_DIVU;
      A = 32'hDEAD_BEEF; B = 32'h0000_0011;
      repeat (3) @(negedge clk);
      check("hi_busy_write", HI, hi_keep);
      Start = 1'b0; WriteHI = 1'b0; WriteLO = 1'b0;
      wait_idle();

      // Back-to-back: Start in the Done cycle is accepted.
      check("done_cycle", Done, 1'b1);
      start_op(OP_DIV, 32'h7FFF_FFFF, 32'hFFFF_FFF0);
      check("done_drops", Done, 1'b0);
      wait_idle();

      // Start wins over WriteHI in the same IDLE cycle.
      hi_keep = HI;
      WriteHI = 1'b1;
      start_op(OP_DIVU, 32'hFFFF_FFFF, 32'd10);
      WriteHI = 1'b0;
      check("start_priority", HI, hi_keep);
      wait_idle();

      // A handful of pseudo-random operations.
      for (int i = 0; i < 8; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = (i == 3) ? 32'd1 : $urandom;
         run_op(2'(i), ra, rb);
      end

      // Reset mid-operation aborts with no Done and cleared HI/LO.
      start_op(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (9) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      sb.delete();
      check("abort_busy", Busy, 1'b0);
      check("abort_hilo", {HI, LO}, 64'd0);
      repeat (40) @(negedge clk);
      check("abort_no_result", {Busy, HI, LO}, 65'd0);

      // mthi / mtlo in IDLE, separately and together.
      WriteHI = 1'b1; A = 32'h1111_2222;
      @(negedge clk);
      WriteHI = 1'b0;
      check("mthi", HI, 32'h1111_2222);
      WriteLO = 1'b1; A = 32'hCAFE_F00D;
      @(negedge clk);
      WriteLO = 1'b0;
      check("mtlo", LO, 32'hCAFE_F00D);
      check("mtlo_hi_kept", HI, 32'h1111_2222);
      WriteHI = 1'b1; WriteLO = 1'b1; A = 32'h0BAD_F00D;
      @(negedge clk);
      WriteHI = 1'b0; WriteLO = 1'b0;
      check("mthi_mtlo", {HI, LO}, {32'h0BAD_F00D, 32'h0BAD_F00D});

      repeat (3) @(negedge clk);
      check("sb_empty", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
